// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader connects as slave; the byte source and memory side connect as master.
interface instr_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_write_en,
        input  mem_write_addr,
        input  mem_write_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_write_en,
        output mem_write_addr,
        output mem_write_data
    );
endinterface

// File: rtl/instr_loader.sv
// Boot-time loader: length-prefixed byte stream in, big-endian 32-bit words written
// to instruction memory at consecutive word addresses, core held in reset until complete.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | after reset, waiting for load_start
// S_HDR_HI | receiving the high byte of word count N
// S_HDR_LO | receiving the low byte of N, then deciding on N
// S_DATA   | receiving instruction bytes, one write per 4 bytes
// S_FLUSH  | strobe of the final word is on the memory port
// S_DONE   | program loaded, core released
// S_ERROR  | header rejected (N > MAX_WORDS), core stays held
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_start,
    instr_loader_if.slave      bus,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  hdr_hi_q;
    logic [15:0] n_q;
    logic [15:0] k_q;
    logic [1:0]  b_q;
    logic [23:0] asm_q;

    logic        accept;
    logic [15:0] hdr_n;
    logic [31:0] word_d;
    logic        last_word;

    assign bus.byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign hdr_n          = {hdr_hi_q, bus.byte_data};
    assign word_d         = {asm_q, bus.byte_data};
    // 17-bit compare so k+1 cannot wrap when N = 65535
    assign last_word      = (b_q == 2'd3) && (({1'b0, k_q} + 17'd1) == {1'b0, n_q});

    assign cpu_hold = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load_start) state_d = S_HDR_HI;
            S_HDR_HI: if (accept) state_d = S_HDR_LO;
            S_HDR_LO: begin
                if (accept) begin
                    if (hdr_n == 16'd0)                 state_d = S_DONE;
                    else if ({1'b0, hdr_n} > MAX_W)     state_d = S_ERROR;
                    else                                state_d = S_DATA;
                end
            end
            S_DATA:   if (accept && last_word) state_d = S_FLUSH;
            S_FLUSH:  state_d = S_DONE;
            S_DONE,
            S_ERROR:  if (load_start) state_d = S_HDR_HI;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hdr_hi_q           <= 8'd0;
            n_q                <= 16'd0;
            k_q                <= 16'd0;
            b_q                <= 2'd0;
            asm_q              <= 24'd0;
            bus.mem_write_en   <= 1'b0;
            bus.mem_write_addr <= 32'd0;
            bus.mem_write_data <= 32'd0;
        end else begin
            bus.mem_write_en <= 1'b0;
            if (accept) begin
                case (state_q)
                    S_HDR_HI: hdr_hi_q <= bus.byte_data;
                    S_HDR_LO: begin
                        n_q <= hdr_n;
                        k_q <= 16'd0;
                        b_q <= 2'd0;
                    end
                    S_DATA: begin
                        asm_q <= word_d[23:0];
                        b_q   <= b_q + 2'd1;
                        if (b_q == 2'd3) begin
                            bus.mem_write_en   <= 1'b1;
                            bus.mem_write_addr <= BASE_ADDR + {14'd0, k_q, 2'b00};
                            bus.mem_write_data <= word_d;
                            k_q                <= k_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: two instances share one byte stream, the second
// with a non-zero base address; a negedge monitor records every write strobe.
module tb_instr_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ls = 1'b0;
    logic       bv = 1'b0;
    logic [7:0] bd = 8'h00;
    logic       hold0, done0, err0, hold1, done1, err1;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

    instr_loader_if bus0 ();
    instr_loader_if bus1 ();

    assign bus0.byte_valid = bv;
    assign bus0.byte_data  = bd;
    assign bus1.byte_valid = bv;
    assign bus1.byte_data  = bd;

    instr_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
        .clock(clock), .reset(reset), .load_start(ls), .bus(bus0),
        .cpu_hold(hold0), .done(done0), .error(err0)
    );

    instr_loader #(.BASE_ADDR(32'h0040_0000), .MAX_WORDS(256)) dut1 (
        .clock(clock), .reset(reset), .load_start(ls), .bus(bus1),
        .cpu_hold(hold1), .done(done1), .error(err1)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus0.mem_write_en === 1'b1) begin
            wa0.push_back(bus0.mem_write_addr);
            wd0.push_back(bus0.mem_write_data);
        end
        if (bus1.mem_write_en === 1'b1) begin
            wa1.push_back(bus1.mem_write_addr);
            wd1.push_back(bus1.mem_write_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr0(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wa0.size()) begin
            chk({tag, "_addr"}, wa0[idx], a);
            chk({tag, "_data"}, wd0[idx], d);
        end else begin
            chk({tag, "_present"}, 32'(wa0.size()), 32'(idx + 1));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        ls = 1'b1;
        tick();
        ls = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bv = 1'b0;
        repeat (gap) tick();
        bv = 1'b1;
        bd = b;
        for (int n = 0; n < 50 && !bus0.byte_ready; n++) tick();
        chk("accept_ready", {31'd0, bus0.byte_ready}, 32'd1);
        tick();
        bv = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], 0);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], 0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_we",    {31'd0, bus0.mem_write_en}, 32'd0);
        chk("rst_addr",  bus0.mem_write_addr, 32'd0);
        chk("rst_data",  bus0.mem_write_data, 32'd0);
        chk("rst_hold",  {31'd0, hold0}, 32'd1);
        chk("rst_done",  {31'd0, done0}, 32'd0);
        chk("rst_err",   {31'd0, err0}, 32'd0);
        chk("rst_ready", {31'd0, bus0.byte_ready}, 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_ready", {31'd0, bus0.byte_ready}, 32'd0);

        // single word at full rate
        pulse_start();
        chk("t1_hdr_ready", {31'd0, bus0.byte_ready}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h2008_0005, 0);
        chk("t1_we",       {31'd0, bus0.mem_write_en}, 32'd1);
        chk("t1_addr",     bus0.mem_write_addr, 32'h0);
        chk("t1_data",     bus0.mem_write_data, 32'h2008_0005);
        chk("t1_flush_hold", {31'd0, hold0}, 32'd1);
        chk("t1_flush_done", {31'd0, done0}, 32'd0);
        chk("t1_flush_ready", {31'd0, bus0.byte_ready}, 32'd0);
        tick();
        chk("t1_done",  {31'd0, done0}, 32'd1);
        chk("t1_hold",  {31'd0, hold0}, 32'd0);
        chk("t1_we_off", {31'd0, bus0.mem_write_en}, 32'd0);
        chk("t1_count", 32'(wa0.size()), 32'd1);
        chk_wr0("t1_w0", 0, 32'h0, 32'h2008_0005);

        // three words with gaps, restart from DONE
        wa0.delete(); wd0.delete();
        pulse_start();
        chk("t2_hold_up", {31'd0, hold0}, 32'd1);
        chk("t2_done_clr", {31'd0, done0}, 32'd0);
        send_byte(8'h00, 2);
        send_byte(8'h03, 1);
        send_word(32'h1122_3344, 3);
        send_word(32'h5566_7788, 1);
        send_word(32'h99AA_BBCC, 2);
        chk("t2_ready_end", {31'd0, bus0.byte_ready}, 32'd0);
        tick();
        repeat (2) tick();
        chk("t2_done",  {31'd0, done0}, 32'd1);
        chk("t2_count", 32'(wa0.size()), 32'd3);
        chk_wr0("t2_w0", 0, 32'h0, 32'h1122_3344);
        chk_wr0("t2_w1", 1, 32'h4, 32'h5566_7788);
        chk_wr0("t2_w2", 2, 32'h8, 32'h99AA_BBCC);
        chk("t2_addr_hold", bus0.mem_write_addr, 32'h8);
        chk("t2_data_hold", bus0.mem_write_data, 32'h99AA_BBCC);

        // N = 0
        wa0.delete(); wd0.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("n0_done",  {31'd0, done0}, 32'd1);
        chk("n0_hold",  {31'd0, hold0}, 32'd0);
        chk("n0_ready", {31'd0, bus0.byte_ready}, 32'd0);
        repeat (2) tick();
        chk("n0_count", 32'(wa0.size()), 32'd0);

        // N = MAX_WORDS (largest accepted)
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 256; k++) begin
            send_word({8'hA5, 8'(k), 8'h5A, ~8'(k)}, 0);
        end
        tick();
        chk("nmax_done",  {31'd0, done0}, 32'd1);
        chk("nmax_err",   {31'd0, err0}, 32'd0);
        chk("nmax_count", 32'(wa0.size()), 32'd256);
        chk_wr0("nmax_w128", 128, 32'h200, 32'hA580_5A7F);
        chk_wr0("nmax_w255", 255, 32'h3FC, 32'hA5FF_5A00);

        // N = MAX_WORDS + 1
        wa0.delete(); wd0.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("err_err",   {31'd0, err0}, 32'd1);
        chk("err_hold",  {31'd0, hold0}, 32'd1);
        chk("err_done",  {31'd0, done0}, 32'd0);
        chk("err_ready", {31'd0, bus0.byte_ready}, 32'd0);
        bv = 1'b1;
        bd = 8'hEE;
        repeat (3) tick();
        bv = 1'b0;
        chk("err_count", 32'(wa0.size()), 32'd0);
        chk("err_still", {31'd0, err0}, 32'd1);

        // recover with N = 1
        pulse_start();
        chk("rec_err_clr", {31'd0, err0}, 32'd0);
        chk("rec_hold",    {31'd0, hold0}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hDEAD_BEEF, 1);
        tick();
        chk("rec_done",  {31'd0, done0}, 32'd1);
        chk("rec_count", 32'(wa0.size()), 32'd1);
        chk_wr0("rec_w0", 0, 32'h0, 32'hDEAD_BEEF);

        // reset mid-word
        wa0.delete(); wd0.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h0102_0304, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_we",    {31'd0, bus0.mem_write_en}, 32'd0);
        chk("mid_addr",  bus0.mem_write_addr, 32'd0);
        chk("mid_data",  bus0.mem_write_data, 32'd0);
        chk("mid_hold",  {31'd0, hold0}, 32'd1);
        chk("mid_done",  {31'd0, done0}, 32'd0);
        chk("mid_ready", {31'd0, bus0.byte_ready}, 32'd0);
        chk("mid_count", 32'(wa0.size()), 32'd1);
        reset = 1'b1;
        tick();
        wa0.delete(); wd0.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'hCAFE_F00D, 0);
        send_word(32'h0BAD_C0DE, 0);
        tick();
        chk("fresh_done",  {31'd0, done0}, 32'd1);
        chk("fresh_count", 32'(wa0.size()), 32'd2);
        chk_wr0("fresh_w0", 0, 32'h0, 32'hCAFE_F00D);
        chk_wr0("fresh_w1", 1, 32'h4, 32'h0BAD_C0DE);

        // load_start during DATA is ignored
        wa0.delete(); wd0.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        pulse_start();
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        pulse_start();
        send_word(32'h9ABC_DEF0, 0);
        tick();
        chk("ign_done",  {31'd0, done0}, 32'd1);
        chk("ign_count", 32'(wa0.size()), 32'd2);
        chk_wr0("ign_w0", 0, 32'h0, 32'h1234_5678);
        chk_wr0("ign_w1", 1, 32'h4, 32'h9ABC_DEF0);

        // restart from DONE on the non-zero base instance
        wa1.delete(); wd1.delete();
        chk("base_pre_hold", {31'd0, hold1}, 32'd0);
        pulse_start();
        chk("base_hold_up", {31'd0, hold1}, 32'd1);
        chk("base_done_clr", {31'd0, done1}, 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h1357_9BDF, 0);
        tick();
        chk("base_done",  {31'd0, done1}, 32'd1);
        chk("base_count", 32'(wa1.size()), 32'd1);
        if (wa1.size() > 0) begin
            chk("base_addr", wa1[0], 32'h0040_0000);
            chk("base_data", wd1[0], 32'h1357_9BDF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
